// File: rtl/instr_split_queue_pkg.sv
// Shared MIPS instruction field layout and helpers for the IF->ID prefetch queue.
package instr_split_queue_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;

    localparam int OP_HI  = 31;
    localparam int OP_LO  = 26;
    localparam int RS_HI  = 25;
    localparam int RS_LO  = 21;
    localparam int RT_HI  = 20;
    localparam int RT_LO  = 16;
    localparam int RD_HI  = 15;
    localparam int RD_LO  = 11;
    localparam int SH_HI  = 10;
    localparam int SH_LO  = 6;
    localparam int FN_HI  = 5;
    localparam int FN_LO  = 0;
    localparam int IMM_HI = 15;
    localparam int IMM_LO = 0;
    localparam int JI_HI  = 25;
    localparam int JI_LO  = 0;

    // Upper nibble of pc+4: the 256 MB region a J/JAL target lands in.
    function automatic logic [3:0] jump_region(input logic [31:0] pc);
        return 4'((pc + 32'd4) >> 28);
    endfunction

endpackage

// File: rtl/instr_split_queue_field_decode.sv
// Combinational split of the queue head word into MIPS fields; all outputs zero when not valid.
module instr_field_decode
    import instr_split_queue_pkg::*;
#(
    parameter int PC_W = 32
) (
    input  logic            valid,
    input  logic [31:0]     instr,
    input  logic [PC_W-1:0] pc,
    output logic [5:0]      op,
    output logic [5:0]      func,
    output logic [4:0]      rs,
    output logic [4:0]      rt,
    output logic [4:0]      rd,
    output logic [4:0]      shamt,
    output logic [15:0]     imm16,
    output logic [31:0]     imm_sext,
    output logic [31:0]     imm_zext,
    output logic [25:0]     jidx,
    output logic [31:0]     jtarget,
    output logic            is_rtype
);

    logic [31:0] pc32;

    if (PC_W >= 32) begin : g_pc_wide
        assign pc32 = pc[31:0];
    end else begin : g_pc_narrow
        assign pc32 = {{(32 - PC_W){1'b0}}, pc};
    end

    always_comb begin
        op       = '0;
        func     = '0;
        rs       = '0;
        rt       = '0;
        rd       = '0;
        shamt    = '0;
        imm16    = '0;
        imm_sext = '0;
        imm_zext = '0;
        jidx     = '0;
        jtarget  = '0;
        is_rtype = 1'b0;
        if (valid) begin
            op       = instr[OP_HI:OP_LO];
            func     = instr[FN_HI:FN_LO];
            rs       = instr[RS_HI:RS_LO];
            rt       = instr[RT_HI:RT_LO];
            rd       = instr[RD_HI:RD_LO];
            shamt    = instr[SH_HI:SH_LO];
            imm16    = instr[IMM_HI:IMM_LO];
            imm_sext = {{16{instr[IMM_HI]}}, instr[IMM_HI:IMM_LO]};
            imm_zext = {16'b0, instr[IMM_HI:IMM_LO]};
            jidx     = instr[JI_HI:JI_LO];
            jtarget  = {jump_region(pc32), instr[JI_HI:JI_LO], 2'b00};
            is_rtype = (instr[OP_HI:OP_LO] == OP_RTYPE);
        end
    end

endmodule

// File: rtl/instr_split_queue.sv
// IF->ID prefetch queue: circular buffer of {pc, instr} with valid/ready on both sides,
// head presented first-word-fall-through and pre-split into MIPS fields.
module instr_split_queue
    import instr_split_queue_pkg::*;
#(
    parameter  int DEPTH = 4,
    parameter  int PC_W  = 32,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [PC_W-1:0]  in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic [PC_W-1:0]  out_pc,
    output logic [5:0]       op,
    output logic [5:0]       func,
    output logic [4:0]       rs,
    output logic [4:0]       rt,
    output logic [4:0]       rd,
    output logic [4:0]       shamt,
    output logic [15:0]      imm16,
    output logic [31:0]      imm_sext,
    output logic [31:0]      imm_zext,
    output logic [25:0]      jidx,
    output logic [31:0]      jtarget,
    output logic             is_rtype,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [31:0]      instr_mem_q [DEPTH];
    logic [PC_W-1:0]  pc_mem_q    [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push, pop;

    assign in_ready  = (count_q != CNT_W'(DEPTH));
    assign out_valid = (count_q != '0);
    assign count     = count_q;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Flush shares the reset path: a redirect drops same-cycle push and pop alike.
    always_ff @(posedge clk) begin
        if (!reset_n || flush) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem_q[wr_ptr_q] <= in_instr;
            pc_mem_q[wr_ptr_q]    <= in_pc;
        end
    end

    // Masking keeps uninitialised storage from leaking X onto the outputs.
    assign out_instr = out_valid ? instr_mem_q[rd_ptr_q] : '0;
    assign out_pc    = out_valid ? pc_mem_q[rd_ptr_q]    : '0;

    instr_field_decode #(
        .PC_W(PC_W)
    ) u_decode (
        .valid   (out_valid),
        .instr   (out_instr),
        .pc      (out_pc),
        .op      (op),
        .func    (func),
        .rs      (rs),
        .rt      (rt),
        .rd      (rd),
        .shamt   (shamt),
        .imm16   (imm16),
        .imm_sext(imm_sext),
        .imm_zext(imm_zext),
        .jidx    (jidx),
        .jtarget (jtarget),
        .is_rtype(is_rtype)
    );

endmodule

// File: tb/tb_instr_split_queue.sv
// Directed self-checking bench for instr_split_queue (DEPTH=4, PC_W=32).
module tb_instr_split_queue;

    logic        clk = 1'b0;
    logic        reset_n, flush, in_valid, out_ready;
    logic        in_ready, out_valid, is_rtype;
    logic [31:0] in_instr, in_pc, out_instr, out_pc;
    logic [5:0]  op, func;
    logic [4:0]  rs, rt, rd, shamt;
    logic [15:0] imm16;
    logic [31:0] imm_sext, imm_zext, jtarget;
    logic [25:0] jidx;
    logic [2:0]  count;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    always #5 clk = ~clk;

    instr_split_queue #(
        .DEPTH(4),
        .PC_W (32)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_instr (in_instr),
        .in_pc    (in_pc),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_instr(out_instr),
        .out_pc   (out_pc),
        .op       (op),
        .func     (func),
        .rs       (rs),
        .rt       (rt),
        .rd       (rd),
        .shamt    (shamt),
        .imm16    (imm16),
        .imm_sext (imm_sext),
        .imm_zext (imm_zext),
        .jidx     (jidx),
        .jtarget  (jtarget),
        .is_rtype (is_rtype),
        .count    (count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input logic [31:0] w, input logic [31:0] pc);
        in_valid = 1'b1;
        in_instr = w;
        in_pc    = pc;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic pop_one();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_count"},    32'(count),     32'd0);
        chk({tag, "_outvalid"}, 32'(out_valid), 32'd0);
        chk({tag, "_inready"},  32'(in_ready),  32'd1);
        chk({tag, "_instr"},    out_instr,      32'd0);
        chk({tag, "_pc"},       out_pc,         32'd0);
        chk({tag, "_op"},       32'(op),        32'd0);
        chk({tag, "_rs"},       32'(rs),        32'd0);
        chk({tag, "_sext"},     imm_sext,       32'd0);
        chk({tag, "_jtarget"},  jtarget,        32'd0);
        chk({tag, "_isr"},      32'(is_rtype),  32'd0);
    endtask

    initial begin
        reset_n   = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_instr  = '0;
        in_pc     = '0;
        tick();
        tick();
        reset_n = 1'b1;
        chk_idle("reset");

        // R-type add $8,$9,$10
        push_one(32'h012A4020, 32'h0000_3000);
        chk("r_valid", 32'(out_valid), 32'd1);
        chk("r_count", 32'(count),     32'd1);
        chk("r_instr", out_instr,      32'h012A4020);
        chk("r_pc",    out_pc,         32'h0000_3000);
        chk("r_op",    32'(op),        32'd0);
        chk("r_rs",    32'(rs),        32'd9);
        chk("r_rt",    32'(rt),        32'd10);
        chk("r_rd",    32'(rd),        32'd8);
        chk("r_shamt", 32'(shamt),     32'd0);
        chk("r_func",  32'(func),      32'h20);
        chk("r_isr",   32'(is_rtype),  32'd1);
        pop_one();
        chk_idle("r_pop");

        // addiu $8,$0,-1
        push_one(32'h2408FFFF, 32'h0000_3004);
        chk("i_op",    32'(op),       32'd9);
        chk("i_rt",    32'(rt),       32'd8);
        chk("i_imm16", 32'(imm16),    32'h0000FFFF);
        chk("i_sext",  imm_sext,      32'hFFFFFFFF);
        chk("i_zext",  imm_zext,      32'h0000FFFF);
        chk("i_isr",   32'(is_rtype), 32'd0);
        pop_one();

        // jal with three pcs: plain, top region, and pc+4 carrying into bit 28
        push_one(32'h0C000C00, 32'h0000_3000);
        push_one(32'h0C000C00, 32'hF000_0000);
        push_one(32'h0C000C00, 32'h0FFF_FFFC);
        chk("j_count", 32'(count), 32'd3);
        chk("j_op",    32'(op),    32'd3);
        chk("j_jidx",  32'(jidx),  32'h0000C00);
        chk("j_tgt0",  jtarget,    32'h0000_3000);
        pop_one();
        chk("j_tgt1",  jtarget,    32'hF000_3000);
        pop_one();
        chk("j_tgt2",  jtarget,    32'h1000_3000);
        pop_one();
        chk("j_empty", 32'(out_valid), 32'd0);

        // Fill to DEPTH, then a fifth offer must be refused
        for (int unsigned i = 0; i < 4; i++) push_one(32'h1111_0000 + i, 32'h100 + 4 * i);
        chk("full_count",   32'(count),    32'd4);
        chk("full_inready", 32'(in_ready), 32'd0);
        push_one(32'h1111_0004, 32'h110);
        chk("full_count5",  32'(count),    32'd4);
        for (int unsigned i = 0; i < 4; i++) begin
            chk("full_order", out_instr, 32'h1111_0000 + i);
            chk("full_pc",    out_pc,    32'h100 + 4 * i);
            pop_one();
        end
        chk_idle("drain");

        // Steady push+pop at count=2 across several pointer wraps
        push_one(32'h2222_0000, 32'h200);
        push_one(32'h2222_0001, 32'h204);
        for (int unsigned k = 0; k < 12; k++) begin
            chk("wrap_head", out_instr, 32'h2222_0000 + k);
            in_valid  = 1'b1;
            in_instr  = 32'h2222_0002 + k;
            in_pc     = 32'h208 + 4 * k;
            out_ready = 1'b1;
            tick();
            chk("wrap_count", 32'(count), 32'd2);
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("wrap_tail0", out_instr, 32'h2222_000C);
        pop_one();
        chk("wrap_tail1", out_instr, 32'h2222_000D);
        chk("wrap_pc1",   out_pc,    32'h234);
        pop_one();
        chk("wrap_empty", 32'(count), 32'd0);

        // Flush with concurrent push/pop offered
        for (int unsigned i = 0; i < 3; i++) push_one(32'h3333_0000 + i, 32'h300 + 4 * i);
        chk("fl_pre", 32'(count), 32'd3);
        flush     = 1'b1;
        in_valid  = 1'b1;
        in_instr  = 32'h3333_00FF;
        out_ready = 1'b1;
        tick();
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk_idle("flush");
        push_one(32'h3333_0010, 32'h400);
        chk("fl_after", out_instr, 32'h3333_0010);
        chk("fl_cnt",   32'(count), 32'd1);
        pop_one();

        // Same scenario through reset_n
        for (int unsigned i = 0; i < 3; i++) push_one(32'h4444_0000 + i, 32'h500 + 4 * i);
        chk("rs_pre", 32'(count), 32'd3);
        reset_n   = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'h4444_00FF;
        out_ready = 1'b1;
        tick();
        reset_n   = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk_idle("rst");
        push_one(32'h4444_0010, 32'h600);
        chk("rs_after", out_instr, 32'h4444_0010);
        chk("rs_pc",    out_pc,    32'h600);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
